// File: rtl/sample_avg.sv
// sample_avg: captures one fine SAR code per rising edge of valid, forms a
// rounded boxcar average of 2^LOG2N samples, strobes it out, and shifts each
// new average MSB-first on a framed serial pin.
module sample_avg #(
  parameter int LOG2N = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pwrup,
  input  logic       valid,
  input  logic [7:0] ibf,
  output logic [7:0] avg,
  output logic       avg_stb,
  output logic       sframe,
  output logic       sdo
);

  localparam int N  = 1 << LOG2N;
  localparam int AW = 8 + LOG2N;   // accumulator width
  localparam int CW = LOG2N + 1;   // sample counter width
  localparam int SW = 9 + LOG2N;   // width of the final rounded sum

  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [SW-1:0] HALF     = SW'(N / 2);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  logic          valid_d;
  logic [AW-1:0] acc;
  logic [CW-1:0] cnt;
  state_t        state;
  logic [2:0]    bc;
  logic [7:0]    sr;
  logic          pend;

  logic          sample_ev;
  logic [SW-1:0] sum_s;
  logic [7:0]    avg_next;
  logic          load_s;

  // Sample event detect and rounded average of the completed window.
  always_comb begin
    sample_ev = valid & ~valid_d & pwrup;
    // Sum of N codes plus N/2 stays below 256*N, so 9+LOG2N bits never wrap.
    sum_s     = SW'(acc) + SW'(ibf) + HALF;
    avg_next  = 8'(sum_s >> LOG2N);
  end

  // Accumulate samples and publish the average with a one-cycle strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_d <= 1'b0;
      acc     <= '0;
      cnt     <= '0;
      avg     <= 8'h00;
      avg_stb <= 1'b0;
    end else begin
      valid_d <= valid;
      avg_stb <= 1'b0;
      if (!pwrup) begin
        // Powered down: a partial window is worthless, restart from scratch.
        acc <= '0;
        cnt <= '0;
      end else if (sample_ev) begin
        if (cnt == CNT_LAST) begin
          avg     <= avg_next;
          avg_stb <= 1'b1;
          acc     <= '0;
          cnt     <= '0;
        end else begin
          acc <= acc + AW'(ibf);
          cnt <= cnt + CW'(1);
        end
      end else begin
        acc <= acc;
        cnt <= cnt;
      end
    end
  end

  // Decide when the serializer takes a new word from avg.
  always_comb begin
    load_s = 1'b0;
    case (state)
      S_IDLE:  load_s = pend;
      // A strobe landing on the last bit is picked up on that same boundary.
      S_SHIFT: load_s = (bc == 3'd7) && (pend || avg_stb);
      default: load_s = 1'b0;
    endcase
  end

  // Serializer: one pending slot, latest average wins, frames back to back.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      bc     <= 3'd0;
      sr     <= 8'h00;
      pend   <= 1'b0;
      sframe <= 1'b0;
      sdo    <= 1'b0;
    end else if (load_s) begin
      state  <= S_SHIFT;
      sr     <= avg;
      bc     <= 3'd0;
      pend   <= 1'b0;
      sframe <= 1'b1;
      sdo    <= avg[7];
    end else begin
      if (avg_stb) begin
        pend <= 1'b1;
      end else begin
        pend <= pend;
      end
      if (state == S_SHIFT) begin
        if (bc == 3'd7) begin
          state  <= S_IDLE;
          sframe <= 1'b0;
          sdo    <= 1'b0;
        end else begin
          // sdo always mirrors sr[7] while shifting.
          sr     <= sr << 1;
          bc     <= bc + 3'd1;
          sframe <= 1'b1;
          sdo    <= sr[6];
        end
      end else begin
        sframe <= 1'b0;
        sdo    <= 1'b0;
      end
    end
  end

endmodule

// File: doc/sample_avg.md
# sample_avg

Downstream consumer of the temperature-sensor core controller's fine SAR result. Captures the 8-bit fine code `ibf` once per `valid` assertion, forms a rounded boxcar average of 2^LOG2N consecutive conversions, publishes it with a one-cycle strobe, and shifts each new average out MSB-first on a framed serial pin for the chip-level readout.

## Interface

- `LOG2N`, default 3: log2 of samples per average; legal range 0..4 (1..16 samples).

Ports:
- `clk`  in  1  system clock (10 MHz, same as the core controller).
- `reset`  in  1  synchronous, active-high reset.
- `pwrup`  in  1  sensor powered; when low, the accumulation is discarded and no samples are captured.
- `valid`  in  1  core result-valid level; may stay high for several consecutive cycles.
- `ibf`  in  8  fine code from the core; stable whenever `valid` is high.
- `avg`  out  8  latest completed average.
- `avg_stb`  out  1  one-cycle pulse: `avg` was just updated.
- `sframe`  out  1  serial frame; high for exactly 8 cycles per transmitted word.
- `sdo`  out  1  serial data, MSB first, valid while `sframe` is high; 0 otherwise.

## Operation

- Edge detect: `valid_d` registers `valid`. A sample event is `valid & ~valid_d & pwrup`. One assertion yields exactly one sample, regardless of its length.
- Accumulator: `acc`, 8+LOG2N bits, unsigned. Sample counter `cnt`, LOG2N+1 bits.
- On a sample event with `cnt < N-1`: `acc <= acc + ibf`, `cnt <= cnt + 1`.
- On a sample event with `cnt == N-1`:
  - `avg <= (acc + ibf + N/2) >> LOG2N`, computed at 9+LOG2N bits. Rounding is half-up. The result never exceeds 255, so no saturation logic is needed. For LOG2N=0 the rounding term is 0 and `avg = ibf`.
  - `avg_stb <= 1` for one cycle.
  - `acc <= 0`, `cnt <= 0`.
- `pwrup` low: `acc` and `cnt` clear every cycle and no sample events occur. `avg` holds its value and the serializer continues.
- Serializer FSM:
  - States: S_IDLE, S_SHIFT. It has a 3-bit bit counter `bc`, an 8-bit shift register `sr`, and a `pend` flag.
  - `avg_stb` sets `pend`.
  - S_IDLE with `pend`: `sr <= avg`, `pend <= 0`, `bc <= 0`, go to S_SHIFT.
  - S_SHIFT: `sframe = 1`, `sdo = sr[7]`. Each cycle `sr <= sr << 1` and `bc <= bc + 1`.
  - When `bc == 7`, the FSM leaves S_SHIFT. If `pend` is set it loads the new word immediately, with no gap. Otherwise it goes to S_IDLE.
- `avg_stb` during a frame: the current frame completes unchanged. The next frame carries the `avg` value at load time, so the latest average wins if several strobes arrive during one frame. `pend` is set only once; it does not count strobes.
- Simultaneous `avg_stb` and frame end in the same cycle: the new word loads on that boundary.

## Timing

- Reset values: `avg`=0x00, `avg_stb`=0, `sframe`=0, `sdo`=0. Internally `acc`=0, `cnt`=0, `valid_d`=0, `pend`=0, and the FSM is in S_IDLE.
- Reset takes priority over all other logic. Reset mid-frame forces `sframe`/`sdo` low on the next cycle and drops any partial average.
- Let T be the cycle in which `valid` rises with the Nth sample.
  - `avg`/`avg_stb` are visible in T+1.
  - The serializer sees `pend` in T+2 and loads `sr`.
  - `sframe` is high in T+3..T+10 (8 cycles), carrying bits 7..0 in that order.
- Throughput: a new frame can start every 8 cycles. The core delivers at most one sample per ~10 cycles, so no result is ever lost for any LOG2N.
- `valid` already high when `reset` deasserts: `valid_d` is 0 after reset, so this counts as one sample event if `pwrup` is high.

## Test plan

- Constant input, LOG2N=3: 8 `valid` pulses with `ibf`=0x7F -> one `avg_stb` one cycle after the 8th rise, `avg`=0x7F; serial word 0111_1111 over 8 `sframe` cycles starting 3 cycles after that rise.
- Rounding, LOG2N=2:
  - Samples 10,10,10,11 (sum 41) -> `avg`=10.
  - Samples 10,10,11,11 (sum 42) -> `avg`=11.
  - Samples 255×4 -> `avg`=255.
- Stretched `valid`: 8 assertions each held 3 cycles, `ibf`=0x40 -> exactly one `avg_stb`, `avg`=0x40; no extra samples counted.
- `pwrup` drop: 5 samples, `pwrup` low for 2 cycles, then 8 samples of 0x20 -> `avg`=0x20. The first 5 samples are discarded, and `avg` keeps its prior value throughout.
- Back-to-back frames, LOG2N=0:
  - Drive `valid` pulses 4 cycles apart with `ibf` = 0xA5, 0x3C, 0xF0.
  - The first frame carries 0xA5.
  - The following frame starts with no idle gap and carries the `avg` current at load time; no more than one word is queued.
- Reset mid-frame: assert `reset` during bit 3 of a frame -> `sframe`=0, `sdo`=0, `avg`=0 on the next cycle. The next 8 samples produce a correct fresh average.
